// File: rtl/polydiv_pkg.sv
// rtl/polydiv_pkg.sv - shared widths, field constants and FSM state type for the polydiv sequencer
package polydiv_pkg;
    localparam int AW          = 11;
    localparam int DW          = 13;
    localparam int P           = 757;
    localparam int Q           = 4591;
    localparam int TIMEOUT_CYC = 4096;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        SCAN_RD,
        SCAN_CHK,
        DONE
    } state_t;
endpackage

// File: rtl/polydiv_deg_scan.sv
// rtl/polydiv_deg_scan.sv - downward remainder-memory scan for the next nonzero coefficient
module polydiv_deg_scan
    import polydiv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [AW-1:0] from,
    input  logic          rd,
    input  logic          chk,
    output logic          scan_re,
    output logic [AW-1:0] scan_addr,
    input  logic [DW-1:0] scan_data,
    output logic          found,
    output logic          zero,
    output logic [AW-1:0] deg
);
    logic [AW-1:0] ptr;
    logic          data_zero;

    assign data_zero = (scan_data == '0);

    // ptr stops at 0 so the scan never wraps to the top index.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (go) begin
            ptr <= from;
        end else if (chk && data_zero && ptr != '0) begin
            ptr <= ptr - 1'b1;
        end
    end

    assign scan_re   = rd;
    assign scan_addr = ptr;
    assign found     = chk && !data_zero;
    assign zero      = chk && data_zero && (ptr == '0);
    assign deg       = ptr;
endmodule

// File: rtl/polydiv_seq.sv
// rtl/polydiv_seq.sv - Rq/R3 long-division sequencer; optional sub-engine watchdog under POLYDIV_TIMEOUT_EN
module polydiv_seq
    import polydiv_pkg::*;
#(
    parameter int TIMEOUT_CYC_P = TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] deg_a,
    input  logic [AW-1:0] deg_b,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] deg_r,
    output logic          zero_rem,
    output logic          err,
    output logic          sub_start,
    output logic [AW-1:0] sub_shift,
    input  logic          sub_done,
    output logic          scan_re,
    output logic [AW-1:0] scan_addr,
    input  logic [DW-1:0] scan_data
);
    state_t        state, state_n;
    logic [AW-1:0] dreg;
    logic          scan_go, scan_found, scan_zero;
    logic [AW-1:0] scan_deg;
    logic          timeout;

    polydiv_deg_scan u_scan (
        .clk       (clk),
        .rst       (rst),
        .go        (scan_go),
        .from      (deg_r - 1'b1),
        .rd        (state == SCAN_RD),
        .chk       (state == SCAN_CHK),
        .scan_re   (scan_re),
        .scan_addr (scan_addr),
        .scan_data (scan_data),
        .found     (scan_found),
        .zero      (scan_zero),
        .deg       (scan_deg)
    );

    assign scan_go   = (state == WAIT) && sub_done && (deg_r != '0);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign sub_start = (state == ISSUE);

`ifdef POLYDIV_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        err_q;

    assign timeout = (state == WAIT) && !sub_done && (wait_cnt == 16'(TIMEOUT_CYC_P - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == IDLE && start) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = CHECK;
            CHECK:    state_n = (deg_r < dreg) ? DONE : ISSUE;
            ISSUE:    state_n = WAIT;
            WAIT: begin
                if (sub_done) begin
                    state_n = (deg_r == '0) ? DONE : SCAN_RD;
                end else if (timeout) begin
                    state_n = DONE;
                end
            end
            SCAN_RD:  state_n = SCAN_CHK;
            SCAN_CHK: begin
                if (scan_found) begin
                    state_n = CHECK;
                end else if (scan_zero) begin
                    state_n = DONE;
                end else begin
                    state_n = SCAN_RD;
                end
            end
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // sub_shift is captured in CHECK so it holds steady through ISSUE and WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            deg_r     <= '0;
            dreg      <= '0;
            sub_shift <= '0;
            zero_rem  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        deg_r    <= deg_a;
                        dreg     <= deg_b;
                        zero_rem <= 1'b0;
                    end
                end
                CHECK: begin
                    if (deg_r >= dreg) sub_shift <= deg_r - dreg;
                end
                WAIT: begin
                    if (sub_done && deg_r == '0) zero_rem <= 1'b1;
                end
                SCAN_CHK: begin
                    if (scan_found) begin
                        deg_r <= scan_deg;
                    end else if (scan_zero) begin
                        deg_r    <= '0;
                        zero_rem <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
